// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM arbiter and its wait counter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_t;

  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_STATES = 2;

endpackage

// File: rtl/sram_wait_ctr.sv
// Loadable down-counter timing the strobe window; last is high while the count equals 1.
module sram_wait_ctr import sram_arb_pkg::*; #(
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_STATES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates CPU and debug-loader access to one SRAM with fixed wait states and a one-cycle ack.
// SRAM_ARB_RR_EN selects round-robin tie-break; otherwise the CPU always wins a tie.
module sram_arbiter import sram_arb_pkg::*; #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  state_t state, state_nxt;
  gnt_t   gnt, gnt_nxt;
  logic   we_q, we_nxt;
  logic   grant;
  logic   last;
  logic   ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt;

`ifdef SRAM_ARB_RR_EN
  logic   last_dbg;
`endif

  sram_wait_ctr #(.WAIT_STATES(WAIT_STATES)) u_wait_ctr (
    .clk   (Clk),
    .rst_n (Reset_n),
    .load  (grant),
    .dec   (state == ACCESS),
    .last  (last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      gnt   <= GNT_CPU;
      we_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      we_q  <= we_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    we_nxt    = we_q;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
          if (cpu_req && dbg_req) begin
`ifdef SRAM_ARB_RR_EN
            gnt_nxt = last_dbg ? GNT_CPU : GNT_DBG;
`else
            gnt_nxt = GNT_CPU;
`endif
          end else begin
            gnt_nxt = cpu_req ? GNT_CPU : GNT_DBG;
          end
          we_nxt = (gnt_nxt == GNT_CPU) ? cpu_we : dbg_we;
        end
      end
      ACCESS:  if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Pins are registered from the next state so they change together with it.
    ce_n_nxt  = (state_nxt != ACCESS);
    oe_n_nxt  = !((state_nxt == ACCESS) && !we_nxt);
    we_n_nxt  = !((state_nxt == ACCESS) && we_nxt);
    dq_oe_nxt = ((state_nxt == ACCESS) || (state_nxt == DONE)) && we_nxt;
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_dbg <= 1'b1;
    end else if (grant) begin
      last_dbg <= (gnt_nxt == GNT_DBG);
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      sram_ce_n  <= ce_n_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
      sram_dq_oe <= dq_oe_nxt;
      cpu_ack    <= (state == ACCESS) && last && (gnt == GNT_CPU);
      dbg_ack    <= (state == ACCESS) && last && (gnt == GNT_DBG);
      if (grant) begin
        sram_addr  <= (gnt_nxt == GNT_CPU) ? cpu_addr  : dbg_addr;
        sram_wdata <= (gnt_nxt == GNT_CPU) ? cpu_wdata : dbg_wdata;
      end
      // Sample the pad on the final strobe cycle; the other port's register holds.
      if ((state == ACCESS) && last && !we_q) begin
        if (gnt == GNT_CPU) cpu_rdata <= sram_rdata;
        else                dbg_rdata <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pin model, vector table, ack scoreboard and tie/reset sequences.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int WS = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [19:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [19:0] dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic [15:0] dbg_rdata;
  logic        dbg_ack;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  always #5 Clk = ~Clk;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  // SRAM model: 256 words indexed by the low address byte.
  logic [15:0] mem [0:255];
  logic        mem_loaded = 1'b0;

  always @(posedge Clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h04] = 16'hBEEF;
      mem_loaded = 1'b1;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mem[sram_addr[7:0]] = sram_wdata;
    end
  end

  always_comb sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hDEAD;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_dbg;
    logic        we;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_cpu_rd = '0;
  logic [15:0] exp_dbg_rd = '0;

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      exp_cpu_rd = '0;
      exp_dbg_rd = '0;
    end else if (cpu_ack || dbg_ack) begin
      chk("ack_onehot", 32'(cpu_ack & dbg_ack), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got cpu_ack=%0b dbg_ack=%0b expected none", cpu_ack, dbg_ack);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_port", 32'(dbg_ack), 32'(mon_e.is_dbg));
        if (!mon_e.we) begin
          if (mon_e.is_dbg) exp_dbg_rd = mon_e.rdata;
          else              exp_cpu_rd = mon_e.rdata;
        end
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
        chk("dbg_rdata", 32'(dbg_rdata), 32'(exp_dbg_rd));
      end
    end
  end

  task automatic push_exp(input logic is_dbg, input logic we, input logic [15:0] rd);
    exp_t e;
    e.is_dbg = is_dbg;
    e.we     = we;
    e.rdata  = rd;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic access(input logic is_dbg, input logic we, input logic [19:0] addr,
                        input logic [15:0] wd, input logic [15:0] erd);
    int   n, oe_lo, we_lo, dq_hi;
    logic addr_ok, got;
    push_exp(is_dbg, we, erd);
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    n = 0; oe_lo = 0; we_lo = 0; dq_hi = 0; addr_ok = 1'b1; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge Clk);
      n++;
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n) we_lo++;
      if (sram_dq_oe) dq_hi++;
      if (!sram_ce_n && sram_addr != addr) addr_ok = 1'b0;
      got = is_dbg ? dbg_ack : cpu_ack;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    chk("ack_latency", n, WS + 1);
    chk("oe_low_cycles", oe_lo, we ? 0 : WS);
    chk("we_low_cycles", we_lo, we ? WS : 0);
    chk("dq_oe_cycles", dq_hi, we ? WS + 1 : 0);
    chk("addr_in_access", 32'(addr_ok), 1);
    if (we) chk("mem_written", 32'(mem[addr[7:0]]), 32'(wd));
    @(negedge Clk);
  endtask

  // Both ports request reads together; the first two acks are timed and attributed.
  task automatic tie(input logic cpu_holds, input logic exp_second_dbg);
    int   n, a1, a2;
    logic p1, p2;
    push_exp(1'b0, 1'b0, 16'hBEEF);
    push_exp(exp_second_dbg, 1'b0, exp_second_dbg ? 16'h1234 : 16'hBEEF);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00004;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 20'h00020;
    n = 0; a1 = 0; a2 = 0; p1 = 1'b0; p2 = 1'b0;
    while (a2 == 0 && n < 30) begin
      @(negedge Clk);
      n++;
      if (cpu_ack || dbg_ack) begin
        if (a1 == 0) begin a1 = n; p1 = dbg_ack; end
        else         begin a2 = n; p2 = dbg_ack; end
        if (cpu_ack && !cpu_holds) cpu_req = 1'b0;
        if (dbg_ack) dbg_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    chk("tie_first_port", 32'(p1), 0);
    chk("tie_first_latency", a1, WS + 1);
    chk("tie_second_port", 32'(p2), 32'(exp_second_dbg));
    chk("tie_second_gap", a2 - a1, WS + 2);
    @(negedge Clk);
  endtask

  typedef struct {
    logic        is_dbg;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [15:0] erd;
  } vec_t;

  vec_t vt [8];

  initial begin
    int   n, a1, a2, acks;
    logic ce_turn, ce_next;

    vt[0] = '{1'b0, 1'b0, 20'h00004, 16'h0000, 16'hBEEF};
    vt[1] = '{1'b0, 1'b1, 20'h00020, 16'h1234, 16'h0000};
    vt[2] = '{1'b1, 1'b0, 20'h00020, 16'h0000, 16'h1234};
    vt[3] = '{1'b1, 1'b1, 20'h00180, 16'hA5A5, 16'h0000};
    vt[4] = '{1'b0, 1'b0, 20'h00180, 16'h0000, 16'hA5A5};
    vt[5] = '{1'b1, 1'b0, 20'h00004, 16'h0000, 16'hBEEF};
    vt[6] = '{1'b0, 1'b1, 20'hFFFFF, 16'h0F0F, 16'h0000};
    vt[7] = '{1'b0, 1'b0, 20'hFFFFF, 16'h0000, 16'h0F0F};

    // Reset values.
    repeat (3) @(negedge Clk);
    chk("rst_ce_n", 32'(sram_ce_n), 1);
    chk("rst_oe_n", 32'(sram_oe_n), 1);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_wdata", 32'(sram_wdata), 0);
    chk("rst_acks", 32'({cpu_ack, dbg_ack}), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_dbg_rdata", 32'(dbg_rdata), 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset asserted in the middle of a CPU write aborts it without an ack.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00010; cpu_wdata = 16'h5555;
    @(negedge Clk);
    chk("abort_we_active", 32'(sram_we_n), 0);
    #2 Reset_n = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 1);
    chk("abort_ce_n", 32'(sram_ce_n), 1);
    chk("abort_dq_oe", 32'(sram_dq_oe), 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (cpu_ack) acks++;
      if (!sram_ce_n) acks++;
    end
    chk("abort_quiet_after", acks, 0);
    chk("abort_mem_untouched", 32'(mem[8'h10]), 0);

    // Single accesses from the vector table.
    for (int i = 0; i < 8; i++) begin
      access(vt[i].is_dbg, vt[i].we, vt[i].addr, vt[i].wd, vt[i].erd);
    end

    // Tie right after reset: CPU first, dbg one period later.
    do_reset();
    tie(1'b0, 1'b1);
    // Both held: the second grant shows the tie-break policy.
`ifdef SRAM_ARB_RR_EN
    tie(1'b1, 1'b1);
`else
    tie(1'b1, 1'b0);
`endif

    // CPU request held through the ack: one IDLE turnaround, then a new access.
    push_exp(1'b0, 1'b0, 16'hA5A5);
    push_exp(1'b0, 1'b0, 16'hA5A5);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00180;
    n = 0; a1 = 0; a2 = 0; ce_turn = 1'b0; ce_next = 1'b1;
    while (a2 == 0 && n < 30) begin
      @(negedge Clk);
      n++;
      if (a1 != 0 && n == a1 + 1) ce_turn = sram_ce_n;
      if (a1 != 0 && n == a1 + 2) ce_next = sram_ce_n;
      if (cpu_ack) begin
        if (a1 == 0) a1 = n;
        else         a2 = n;
      end
    end
    cpu_req = 1'b0;
    chk("held_first_latency", a1, WS + 1);
    chk("held_turnaround_ce_n", 32'(ce_turn), 1);
    chk("held_restart_ce_n", 32'(ce_next), 0);
    chk("held_period", a2 - a1, WS + 2);
    repeat (4) @(negedge Clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single off-chip SRAM between the CPU memory path (MAR/MDR, driven by the instruction sequencer) and a debug/program-loader port. It arbitrates requests, runs each access for a fixed number of wait states, and returns a one-cycle acknowledge with latched read data. This replaces hard-coded wait states in the sequencer with a request/acknowledge handshake.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- WAIT_STATES, 2, cycles strobes are held per access; legal range 1..15
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address (MAR)
- cpu_wdata  in  DATA_W  CPU write data (MDR)
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle and held until the next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same directions, widths and meaning as the cpu_ group, for the loader port
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  data to drive onto the pad
- sram_rdata  in  DATA_W  data from the pad
- sram_dq_oe  out  1  pad tristate enable, 1 = drive sram_wdata
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: all strobes high, sram_dq_oe 0. If any req is high, grant it, latch we/addr/wdata of the granted port into internal registers, load the wait counter with WAIT_STATES, and go to ACCESS.
- ACCESS: sram_ce_n 0, sram_addr from the latched address.
  - Read: sram_oe_n 0.
  - Write: sram_we_n 0 and sram_dq_oe 1.
  - The counter decrements each cycle. On the cycle it reaches 1, a read latches sram_rdata into the granted port's rdata register. Then go to DONE.
- DONE: strobes high, sram_addr held for hold time, sram_dq_oe stays 1 for writes. Pulse the granted port's ack, then go to IDLE.
- Arbitration when both requests are high in IDLE:
  - Grant the port that was not served last (round-robin bit).
  - The round-robin bit updates only on grant.
  - A single requester is always granted.
- Requests are sampled only in IDLE. Request changes during ACCESS/DONE are ignored.
- Ports never see each other's rdata. The non-granted rdata register holds its value.
- Reset values (asynchronous, any state): state IDLE; sram_ce_n/oe_n/we_n 1; sram_dq_oe 0; sram_addr 0; sram_wdata 0; both acks 0; both rdata 0; round-robin bit = "dbg last" so the CPU wins the first tie.
- Reset during ACCESS aborts the access. Strobes go high immediately, with no ack.

## Timing
- Cycle 0 = IDLE with req high. ACCESS occupies cycles 1..WAIT_STATES. Ack is high in cycle WAIT_STATES+1.
- Request-to-ack latency is WAIT_STATES+1 cycles.
- Requester drops req in the cycle after ack. A req still high in the following IDLE cycle starts a new access.
- Minimum access period is WAIT_STATES+2 cycles, including one IDLE turnaround cycle with sram_ce_n high.
- The losing requester of a tie waits exactly one full access period plus turnaround.
- All outputs are registered. No combinational path from req to any output.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin tie-break as above.
- SRAM_ARB_RR_EN undefined: fixed priority, CPU always wins a tie, and the round-robin bit is removed. All other behaviour is identical.

## Structure
- Package sram_arb_pkg holds:
  - state enum (IDLE, ACCESS, DONE)
  - grant enum (GNT_CPU, GNT_DBG)
  - default width constants
- Optional sub-module sram_wait_ctr: loadable down-counter of width $clog2(WAIT_STATES+1) with a "last" flag. Everything else stays in sram_arbiter.

## Test plan
- Reset_n low mid-ACCESS (CPU write to 0x00010) -> sram_we_n/ce_n go 1 within the same cycle, cpu_ack never pulses, state returns to IDLE.
- CPU read of 0x00004 with model data 0xBEEF, WAIT_STATES=2 -> sram_oe_n low in cycles 1-2, cpu_ack in cycle 3, cpu_rdata = 0xBEEF.
- CPU write 0x1234 to 0x00020 -> sram_we_n low in cycles 1-2, sram_dq_oe high in cycles 1-3, model memory holds 0x1234.
- cpu_req and dbg_req high together after reset -> CPU granted first, dbg_ack arrives exactly 4 cycles after cpu_ack. With SRAM_ARB_RR_EN, the next tie goes to dbg; without it, the next tie goes to CPU.
- cpu_req held high through the ack -> a second access starts after exactly one IDLE cycle with sram_ce_n high.
